ccu_req_mux: RTL
================

Name: ccu_req_mux

Overview:
- Upstream arbitration stage of the cache-coherency unit (CCU) control FSM.
- Merges NoMstPorts ACE master request ports into the single CCU request port, one transaction at a time.
- Locks the grant from AR/AW acceptance until the final R or B beat, then routes CCU responses back to the granted master only.
- Required because the CCU FSM samples its request bundle in IDLE without a valid/ready handshake, so its input must stay stable and single-sourced for a whole transaction.

Parameters:
- NoMstPorts, 4, number of ACE master ports; must be >= 2.
- mst_req_t, logic, ACE request bundle type; identical to the CCU request type.
- mst_resp_t, logic, ACE response bundle type; identical to the CCU response type.
- IdxW, $clog2(NoMstPorts), width of the grant index; derived, never overridden.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- mst_req_i  in  NoMstPorts x mst_req_t  requests from the masters.
- mst_resp_o  out  NoMstPorts x mst_resp_t  responses to the masters.
- ccu_req_o  out  mst_req_t  request to the CCU FSM.
- ccu_resp_i  in  mst_resp_t  response from the CCU FSM.
- busy_o  out  1  high while a transaction is locked.
- grant_idx_o  out  IdxW  index of the locked master; 0 when idle.

Behaviour:
- States: IDLE, LOCK_R, LOCK_W, LOCK_ATOP_R. Encoding lives in the package.
- Reset values:
  - state = IDLE; rr_ptr = 0; grant_q = 0.
  - ccu_req_o = '0; every mst_resp_o = '0; busy_o = 0; grant_idx_o = 0.
- Request vector: req[i] = ar_valid[i] | aw_valid[i].
- IDLE:
  - All outputs are '0, so the CCU never sees a request here.
  - If req != 0, pick the first set bit at or above rr_ptr, wrapping modulo NoMstPorts, and register it into grant_q.
  - Next state is LOCK_R if the winner's ar_valid = 1 (AR wins over AW at the same master); otherwise LOCK_W.
  - Decision is registered: one cycle from request to first forwarding.
- Forwarding in every LOCK state:
  - ccu_req_o = mst_req_i[grant_q], with the other address channel's valid forced to 0.
  - LOCK_R forces aw_valid = 0; LOCK_W and LOCK_ATOP_R force ar_valid = 0.
  - LOCK_ATOP_R also forces aw_valid = 0.
  - mst_resp_o[grant_q] = ccu_resp_i; all other mst_resp_o = '0.
  - Non-granted masters therefore see ar_ready = aw_ready = 0 and must hold their requests.
- LOCK_R: exit to IDLE on ccu_resp_i.r_valid & mst_req_i[grant_q].r_ready & ccu_resp_i.r.last.
  - This includes the single-beat CleanUnique acknowledge.
- LOCK_W: on ccu_resp_i.b_valid & b_ready:
  - go to LOCK_ATOP_R if the latched aw.atop[5] = 1;
  - otherwise go to IDLE.
- LOCK_ATOP_R: exit to IDLE on the R last-beat handshake, same condition as LOCK_R.
- atop latching: aw.atop[5] is captured when LOCK_W is entered. Later changes by the master are ignored.
- Round-robin pointer: on every exit to IDLE, rr_ptr <= grant_q + 1, wrapping NoMstPorts-1 -> 0. No other event changes rr_ptr.
- Back-to-back transactions: the cycle after an exit is IDLE, so there is always at least one idle cycle between transactions. The CCU FSM needs this to re-enter its own IDLE.
- Simultaneous events:
  - A request arriving at any master in the exit cycle is not considered until IDLE.
  - The lock never preempts an in-progress transaction.
- busy_o = (state != IDLE). grant_idx_o = grant_q while busy, else 0.
- Reset mid-transaction: state returns to IDLE immediately and all outputs drop to '0. No partial beats are replayed.
- No ID remapping: IDs pass through unchanged, because only one transaction is in flight at a time.

Decomposition:
- Shared package ccu_pkg holds:
  - the state enum for this block;
  - the constant ATOP_R_BIT = 5.
- Sub-module ccu_rr_pick: purely combinational.
  - Inputs: req vector and rr_ptr.
  - Outputs: winner index and any_valid.
  - Parameterised by NoMstPorts.
- Everything else is inline.

Test Plan:
- Single read: master 2 asserts ar_valid with len=3 → one cycle later ccu_req_o.ar_valid=1 and grant_idx_o=2; four R beats reach only mst_resp_o[2]; IDLE is re-entered after the last beat; rr_ptr=3.
- Fairness: masters 0, 1 and 3 all request reads continuously from reset → grant order is 0, 1, 3, 0, with each master receiving its own R data.
- Same-master AR+AW: master 1 asserts ar_valid and aw_valid together → LOCK_R is served first with aw_valid masked; LOCK_W follows after one idle cycle; the B response arrives at master 1.
- Atomic write: aw.atop=6'b100000 at master 0 → after the B handshake the state is LOCK_ATOP_R; the single R beat with last=1 is routed to master 0; then IDLE.
- Stall isolation: master 3 holds r_ready=0 for 5 cycles → ccu_req_o.r_ready=0 for those cycles; master 2 sees aw_ready=0 throughout; no transaction completes early.
- Reset during beat 2 of a 4-beat read → next cycle busy_o=0, ccu_req_o='0, all mst_resp_o='0; after release, master 0 wins (rr_ptr=0).

Source files
------------

// File: rtl/ccu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ccu_pkg
// Description : Shared types and constants for the CCU request path: the
//               request-mux state encoding, the atomic-op read bit and
//               compact ACE request/response bundles.
// Revision    : 1.0 - initial release
// ============================================================================
package ccu_pkg;

  // Request-mux state encoding
  typedef logic [1:0] mux_state_t;
  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] LOCK_R      = 2'd1;
  localparam logic [1:0] LOCK_W      = 2'd2;
  localparam logic [1:0] LOCK_ATOP_R = 2'd3;

  // aw.atop bit that marks an atomic which also returns read data
  localparam int unsigned ATOP_R_BIT = 5;

  typedef struct packed {
    logic [3:0]  id;
    logic [15:0] addr;
    logic [7:0]  len;
  } ace_ar_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [15:0] addr;
    logic [7:0]  len;
    logic [5:0]  atop;
  } ace_aw_t;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } ace_w_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } ace_b_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } ace_r_t;

  typedef struct packed {
    ace_ar_t ar;
    logic    ar_valid;
    ace_aw_t aw;
    logic    aw_valid;
    ace_w_t  w;
    logic    w_valid;
    logic    b_ready;
    logic    r_ready;
  } ace_req_t;

  typedef struct packed {
    logic   ar_ready;
    logic   aw_ready;
    logic   w_ready;
    ace_b_t b;
    logic   b_valid;
    ace_r_t r;
    logic   r_valid;
  } ace_resp_t;

endpackage
`default_nettype wire

// File: rtl/ccu_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : ccu_rr_pick
// Description : Combinational round-robin picker. Returns the first set
//               request bit at or above rr_ptr_i, wrapping modulo NoMstPorts.
// Revision    : 1.0 - initial release
// ============================================================================
module ccu_rr_pick #(
  parameter  int unsigned NoMstPorts = 4,
  localparam int unsigned IdxW       = $clog2(NoMstPorts)
) (
  input  logic [NoMstPorts-1:0] req_i,
  input  logic [IdxW-1:0]       rr_ptr_i,
  output logic [IdxW-1:0]       winner_o,
  output logic                  any_valid_o
);

  // Candidate index for each search offset, rr_ptr_i + k modulo NoMstPorts
  logic [IdxW-1:0] w_cand [NoMstPorts];

  for (genvar k = 0; k < NoMstPorts; k++) begin : g_cand
    assign w_cand[k] = IdxW'((int'(rr_ptr_i) + k) % NoMstPorts);
  end

  // Scan from the farthest offset down so the nearest requester wins
  always_comb begin
    winner_o = '0;
    for (int k = NoMstPorts - 1; k >= 0; k--) begin
      if (req_i[w_cand[k]]) begin
        winner_o = w_cand[k];
      end
    end
  end

  assign any_valid_o = |req_i;

endmodule
`default_nettype wire

// File: rtl/ccu_req_mux.sv
`default_nettype none
// ============================================================================
// Module      : ccu_req_mux
// Description : Merges NoMstPorts ACE masters onto the single CCU request
//               port. The grant is locked from address acceptance until the
//               final R or B beat, so the CCU sees a stable, single-sourced
//               request bundle for a whole transaction.
// Revision    : 1.0 - initial release
// ============================================================================
module ccu_req_mux
  import ccu_pkg::*;
#(
  parameter  int unsigned NoMstPorts = 4,
  parameter  type         mst_req_t  = ccu_pkg::ace_req_t,
  parameter  type         mst_resp_t = ccu_pkg::ace_resp_t,
  localparam int unsigned IdxW       = $clog2(NoMstPorts)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  mst_req_t        mst_req_i  [NoMstPorts],
  output mst_resp_t       mst_resp_o [NoMstPorts],
  output mst_req_t        ccu_req_o,
  input  mst_resp_t       ccu_resp_i,
  output logic            busy_o,
  output logic [IdxW-1:0] grant_idx_o
);

  mux_state_t            r_state;
  logic [IdxW-1:0]       r_grant;
  logic [IdxW-1:0]       r_rr_ptr;
  logic                  r_atop_r;

  logic [NoMstPorts-1:0] w_req;
  logic [IdxW-1:0]       w_winner;
  logic                  w_any;
  logic                  w_r_done;
  logic                  w_b_done;
  logic [IdxW-1:0]       w_ptr_next;

  // A master requests when either address channel is valid
  for (genvar i = 0; i < NoMstPorts; i++) begin : g_req
    assign w_req[i] = mst_req_i[i].ar_valid | mst_req_i[i].aw_valid;
  end

  ccu_rr_pick #(
    .NoMstPorts (NoMstPorts)
  ) u_rr_pick (
    .req_i       (w_req),
    .rr_ptr_i    (r_rr_ptr),
    .winner_o    (w_winner),
    .any_valid_o (w_any)
  );

  // Completion handshakes as seen by the granted master
  assign w_r_done = ccu_resp_i.r_valid & mst_req_i[r_grant].r_ready & ccu_resp_i.r.last;
  assign w_b_done = ccu_resp_i.b_valid & mst_req_i[r_grant].b_ready;

  // Pointer moves one past the master just served, wrapping at the top port
  assign w_ptr_next = (r_grant == IdxW'(NoMstPorts - 1)) ? '0 : r_grant + 1'b1;

  // Lock FSM: grant in IDLE, hold until the closing R or B beat
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
      r_atop_r <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant <= w_winner;
            if (mst_req_i[w_winner].ar_valid) begin
              r_state <= LOCK_R;
            end else begin
              r_state  <= LOCK_W;
              r_atop_r <= mst_req_i[w_winner].aw.atop[ATOP_R_BIT];
            end
          end
        end
        LOCK_R: begin
          if (w_r_done) begin
            r_state  <= IDLE;
            r_rr_ptr <= w_ptr_next;
          end
        end
        LOCK_W: begin
          if (w_b_done) begin
            if (r_atop_r) begin
              r_state <= LOCK_ATOP_R;
            end else begin
              r_state  <= IDLE;
              r_rr_ptr <= w_ptr_next;
            end
          end
        end
        LOCK_ATOP_R: begin
          if (w_r_done) begin
            r_state  <= IDLE;
            r_rr_ptr <= w_ptr_next;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Forward the granted master with the idle address channel masked off
  always_comb begin
    ccu_req_o  = '0;
    mst_resp_o = '{default: '0};
    if (r_state != IDLE) begin
      ccu_req_o = mst_req_i[r_grant];
      if (r_state == LOCK_R) begin
        ccu_req_o.aw_valid = 1'b0;
      end else begin
        ccu_req_o.ar_valid = 1'b0;
        if (r_state == LOCK_ATOP_R) begin
          ccu_req_o.aw_valid = 1'b0;
        end
      end
      mst_resp_o[r_grant] = ccu_resp_i;
    end
  end

  assign busy_o      = (r_state != IDLE);
  assign grant_idx_o = busy_o ? r_grant : '0;

endmodule
`default_nettype wire
